// File: rtl/frac_div_ctrl.sv
// Fractional-N divide controller: drives a downstream saturating down-counter
// and dithers the period between N and N+1 with a first-order accumulator.
module frac_div_ctrl #(
  parameter int NUM_CNTR_BITS = 5,
  parameter int NUM_FRAC_BITS = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CNTR_BITS:0]   divInt,
  input  logic [NUM_FRAC_BITS-1:0] divFrac,
  input  logic                     zeroed,
  output logic                     load,
  output logic [NUM_CNTR_BITS-1:0] cntrInput,
  output logic                     divPulse,
  output logic                     timeout
);

  localparam int NW = NUM_CNTR_BITS + 2;
  localparam logic [NW-1:0] MIN_N     = NW'(3);
  localparam logic [NW-1:0] CNTR_MAX  = NW'((1 << NUM_CNTR_BITS) - 1);
  // Last WAIT value before the watchdog forces a load (2^NUM_CNTR_BITS+2 WAIT cycles).
  localparam logic [NW-1:0] WDOG_LAST = NW'((1 << NUM_CNTR_BITS) + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  function automatic logic [NW-1:0] clamp_n(input logic [NUM_CNTR_BITS:0] n_int,
                                            input logic carry);
    logic [NW-1:0] n;
    n = (NW'(n_int) < MIN_N) ? MIN_N : NW'(n_int);
    return n + {{(NW-1){1'b0}}, carry};
  endfunction

  function automatic logic [NUM_CNTR_BITS-1:0] sat_cntr(input logic [NW-1:0] n);
    logic [NW-1:0] c;
    c = n - NW'(2);
    if (c > CNTR_MAX) return '1;
    return c[NUM_CNTR_BITS-1:0];
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NUM_FRAC_BITS-1:0] r_acc;
  logic [NW-1:0]            r_wdog;
  logic                     r_load;
  logic                     r_div_pulse;
  logic                     r_timeout;
  logic [NUM_CNTR_BITS-1:0] r_cntr;

  logic [NUM_FRAC_BITS:0]   w_sum;
  logic                     w_carry;
  logic                     w_wdog_exp;
  logic                     w_enter_load;
  logic                     w_forced;
  logic                     w_load_nxt;
  logic                     w_pulse_nxt;
  logic                     w_timeout_nxt;
  logic [NUM_CNTR_BITS-1:0] w_cntr_nxt;
  logic [NUM_FRAC_BITS-1:0] w_acc_nxt;
  logic [NW-1:0]            w_wdog_nxt;

  assign w_sum      = {1'b0, r_acc} + {1'b0, divFrac};
  assign w_carry    = w_sum[NUM_FRAC_BITS];
  assign w_wdog_exp = (r_state == S_WAIT) && (r_wdog == WDOG_LAST);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // enable has priority over zeroed, which has priority over the watchdog
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (enable) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!enable)         w_state_nxt = S_IDLE;
        else if (zeroed)     w_state_nxt = S_LOAD;
        else if (w_wdog_exp) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_enter_load  = (w_state_nxt == S_LOAD);
    w_forced      = (r_state == S_WAIT) && enable && !zeroed && w_wdog_exp;
    w_load_nxt    = w_enter_load;
    w_pulse_nxt   = w_enter_load;
    w_timeout_nxt = r_timeout | w_forced;
    w_cntr_nxt    = w_enter_load ? sat_cntr(clamp_n(divInt, w_carry)) : r_cntr;
    w_acc_nxt     = w_enter_load ? w_sum[NUM_FRAC_BITS-1:0] : r_acc;
    w_wdog_nxt    = (r_state == S_WAIT) ? r_wdog + NW'(1) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_load      <= 1'b0;
      r_div_pulse <= 1'b0;
      r_timeout   <= 1'b0;
      r_cntr      <= '0;
      r_acc       <= '0;
      r_wdog      <= '0;
    end else begin
      r_load      <= w_load_nxt;
      r_div_pulse <= w_pulse_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cntr      <= w_cntr_nxt;
      r_acc       <= w_acc_nxt;
      r_wdog      <= w_wdog_nxt;
    end
  end

  assign load      = r_load;
  assign divPulse  = r_div_pulse;
  assign timeout   = r_timeout;
  assign cntrInput = r_cntr;

endmodule
